// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: receives a little-endian byte stream (word count N, then N
// words), assembles 32-bit instruction words and writes them into the
// instruction memory by word index. busy holds the core in reset meanwhile.
module imem_loader #(
  parameter int unsigned NUM_INSTR = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state, state_next;
  logic [1:0]        byte_cnt, byte_cnt_next;
  logic [31:0]       len_q, len_next;
  logic [31:0]       shift_q, shift_next;
  logic [31:0]       len_asm, word_asm;
  logic [CNT_W-1:0]  words_inc;
  logic              take;

  logic              rx_ready_next, mem_we_next, busy_next, done_next, error_next;
  logic [ADDR_W-1:0] waddr_next;
  logic [31:0]       wdata_next;
  logic [CNT_W-1:0]  words_next;

  // Place byte b into byte lane k of word w (lane k covers bits 8k+7:8k).
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  k,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  assign take = rx_valid && rx_ready;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    len_next      = len_q;
    shift_next    = shift_q;
    waddr_next    = mem_waddr;
    wdata_next    = mem_wdata;
    words_next    = words_loaded;
    len_asm       = put_byte(len_q, byte_cnt, rx_data);
    word_asm      = put_byte(shift_q, byte_cnt, rx_data);
    words_inc     = words_loaded + CNT_W'(1);

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next    = S_LEN;
          byte_cnt_next = 2'd0;
          len_next      = 32'd0;
          shift_next    = 32'd0;
          waddr_next    = '0;
          words_next    = '0;
        end
      end
      S_LEN: begin
        if (take) begin
          len_next      = len_asm;
          byte_cnt_next = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            if (len_asm > 32'(NUM_INSTR)) begin
              state_next = S_ERROR;
            end else if (len_asm == 32'd0) begin
              state_next = S_DONE;
            end else begin
              state_next = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (take) begin
          shift_next    = word_asm;
          byte_cnt_next = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            wdata_next = word_asm;
            state_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // The address is held after the final word so it never wraps.
        words_next = words_inc;
        if (32'(words_inc) == len_q) begin
          state_next = S_DONE;
        end else begin
          waddr_next = mem_waddr + ADDR_W'(1);
          state_next = S_DATA;
        end
      end
      default: state_next = S_IDLE;
    endcase

    rx_ready_next = (state_next == S_LEN) || (state_next == S_DATA);
    busy_next     = rx_ready_next || (state_next == S_WRITE);
    mem_we_next   = (state_next == S_WRITE);
    done_next     = (state_next == S_DONE);
    error_next    = (state_next == S_ERROR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      byte_cnt     <= 2'd0;
      len_q        <= 32'd0;
      shift_q      <= 32'd0;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_next;
      byte_cnt     <= byte_cnt_next;
      len_q        <= len_next;
      shift_q      <= shift_next;
      rx_ready     <= rx_ready_next;
      mem_we       <= mem_we_next;
      mem_waddr    <= waddr_next;
      mem_wdata    <= wdata_next;
      busy         <= busy_next;
      done         <= done_next;
      error        <= error_next;
      words_loaded <= words_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Self-checking bench for imem_loader: random byte streams against a
// queue-based model of the expected memory writes and load outcome.
module tb_imem_loader;

  localparam int unsigned NUM_INSTR = 1024;
  localparam int unsigned ADDR_W    = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.NUM_INSTR(NUM_INSTR), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int                checks = 0;
  int                errors = 0;
  int                we_due = 0;
  int                we_seen = 0;
  logic [7:0]        tx_q[$];
  wr_t               exp_writes[$];
  logic [ADDR_W-1:0] last_waddr;
  logic [31:0]       last_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) tx_q.push_back(w[8*k +: 8]);
  endtask

  // Every-cycle checker: write timing, address/data, output invariants.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      chk("mem_we_timing", 64'(mem_we), 64'(we_due != we_seen));
      if (mem_we) begin
        we_seen++;
        if (exp_writes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", mem_waddr, mem_wdata);
        end else begin
          e = exp_writes.pop_front();
          chk("mem_waddr", 64'(mem_waddr), 64'(e.addr));
          chk("mem_wdata", 64'(mem_wdata), 64'(e.data));
        end
        last_waddr = mem_waddr;
        last_wdata = mem_wdata;
      end
      chk("done_error_excl", 64'(done && error), 64'(0));
      if (!busy) chk("ready_when_idle", 64'(rx_ready), 64'(0));
    end
  endtask

  task automatic pulse_start_check();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_ready", 64'(rx_ready), 64'(1));
    chk("start_done_clr", 64'(done), 64'(0));
    chk("start_error_clr", 64'(error), 64'(0));
    chk("start_words_clr", 64'(words_loaded), 64'(0));
    chk("start_waddr_clr", 64'(mem_waddr), 64'(0));
  endtask

  // Send up to limit bytes of tx_q with random valid gaps; optionally a stray start.
  task automatic send_tx(input int gap_pct, input int start_at, input int limit);
    int  idx = 0;
    int  waitc = 0;
    bit  acc;
    bit  started = 1'b0;
    while (idx < tx_q.size() && idx < limit) begin
      @(negedge clk);
      rx_valid = ($urandom_range(99) >= gap_pct);
      rx_data  = rx_valid ? tx_q[idx] : 8'($urandom);
      start    = (idx == start_at) && !started;
      if (start) started = 1'b1;
      acc = rx_valid && rx_ready;
      @(posedge clk);
      if (acc) begin
        if (idx >= 4 && (idx % 4) == 3) we_due++;
        idx++;
        waitc = 0;
      end else begin
        waitc++;
        if (waitc > 200) begin
          checks++;
          errors++;
          $display("FAIL byte_accept_timeout: byte %0d not accepted", idx);
          break;
        end
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_end(input bit exp_done, input bit exp_err, input int exp_words);
    int w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles", w);
    end
    chk("end_done", 64'(done), 64'(exp_done));
    chk("end_error", 64'(error), 64'(exp_err));
    chk("end_words", 64'(words_loaded), 64'(exp_words));
    chk("end_pending", 64'(exp_writes.size()), 64'(0));
    // Bytes offered after the load must be refused.
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
      chk("post_ready", 64'(rx_ready), 64'(0));
      chk("post_done_hold", 64'(done), 64'(exp_done));
    end
    rx_valid = 1'b0;
  endtask

  // Model: build the stream for length field n and predict writes and outcome.
  task automatic run_load(input logic [31:0] n, input int gap_pct, input int start_at);
    logic [31:0] w;
    bit          legal;
    tx_q.delete();
    push_word(n);
    legal = (n <= 32'(NUM_INSTR));
    if (legal) begin
      for (int i = 0; i < int'(n); i++) begin
        w = $urandom;
        push_word(w);
        exp_writes.push_back('{addr: ADDR_W'(i), data: w});
      end
    end
    pulse_start_check();
    send_tx(gap_pct, start_at, tx_q.size());
    check_end(legal, !legal, legal ? int'(n) : 0);
  endtask

  task automatic load_literal_two();
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00};
    exp_writes.push_back('{addr: ADDR_W'(0), data: 32'h0010_0513});
    exp_writes.push_back('{addr: ADDR_W'(1), data: 32'h0020_0593});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    fork
      monitor();
    join_none

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(rx_ready), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_waddr", 64'(mem_waddr), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_words", 64'(words_loaded), 64'(0));
    rst = 1'b0;

    // Idle with bytes offered: nothing accepted.
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
      chk("idle_ready", 64'(rx_ready), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
      chk("idle_error", 64'(error), 64'(0));
    end
    rx_valid = 1'b0;

    // Hand-computed two-word load, no gaps.
    load_literal_two();
    pulse_start_check();
    send_tx(0, -1, tx_q.size());
    check_end(1'b1, 1'b0, 2);
    chk("lit_last_waddr", 64'(last_waddr), 64'(1));
    chk("lit_last_wdata", 64'(last_wdata), 64'h0020_0593);

    // Same stream with random gaps and a stray start mid-load; restart from DONE.
    load_literal_two();
    pulse_start_check();
    send_tx(50, 6, tx_q.size());
    check_end(1'b1, 1'b0, 2);
    chk("gap_last_wdata", 64'(last_wdata), 64'h0020_0593);

    // Boundary lengths.
    run_load(32'd0, 30, -1);
    run_load(32'd1025, 0, -1);
    run_load(32'h0001_0000, 20, -1);
    run_load(32'($urandom) | 32'h0000_1000, 10, -1);
    run_load(32'd1, 40, -1);
    run_load(32'd1024, 0, 2000);
    chk("max_last_waddr", 64'(last_waddr), 64'(NUM_INSTR - 1));

    // Random short loads with random gaps.
    for (int t = 0; t < 8; t++) begin
      run_load(32'($urandom_range(1, 20)), int'($urandom_range(0, 70)), int'($urandom_range(0, 30)));
    end

    // Reset mid-load: 3-word load cut after two bytes of the second word.
    tx_q.delete();
    push_word(32'd3);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] w;
      w = $urandom;
      push_word(w);
      if (i == 0) exp_writes.push_back('{addr: ADDR_W'(0), data: w});
    end
    pulse_start_check();
    send_tx(0, -1, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_pending", 64'(exp_writes.size()), 64'(0));
    chk("midrst_ready", 64'(rx_ready), 64'(0));
    chk("midrst_we", 64'(mem_we), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_error", 64'(error), 64'(0));
    chk("midrst_waddr", 64'(mem_waddr), 64'(0));
    chk("midrst_wdata", 64'(mem_wdata), 64'(0));
    chk("midrst_words", 64'(words_loaded), 64'(0));
    run_load(32'd1, 0, -1);
    chk("fresh_waddr", 64'(last_waddr), 64'(0));

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
